// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit: default widths, opcodes and FSM encoding.
package alu_exec_unit_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_ADDR_W = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, 32 iterations,
// keeps only the low DATA_W bits of the product.
module alu_mul_iter #(
  parameter int DATA_W = alu_exec_unit_pkg::ALU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic [DATA_W-1:0] product_lo
);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [4:0]        r_cnt;
  logic              r_busy;

  // Load operands on start, then add-and-shift once per cycle until the last iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= {DATA_W{1'b0}};
      r_mplier <= {DATA_W{1'b0}};
      r_acc    <= {DATA_W{1'b0}};
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand  <= operand_a;
      r_mplier <= operand_b;
      r_acc    <= {DATA_W{1'b0}};
      r_cnt    <= 5'd0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy       = r_busy;
  assign product_lo = r_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: captures a request in IDLE, executes in one cycle (or via the
// iterative multiplier), and presents a one-cycle register-bank writeback.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int ADDR_W = ALU_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [ADDR_W-1:0] dest_address,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              carry,
  output logic              zero
);

  state_e            r_state;
  state_e            w_next_state;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_dest;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_carry;
  logic              r_zero;

  logic              w_accept;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic [DATA_W-1:0] w_mul_product;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_carry;
  logic              w_legal;
  logic              w_to_wb;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_mul_start = w_accept && (opcode == OP_MUL);
  assign w_to_wb     = (w_next_state == ST_WB);

  alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .reset      (reset),
    .start      (w_mul_start),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (w_mul_busy),
    .product_lo (w_mul_product)
  );

  // The extra top bit carries out of ADD and signals borrow out of SUB.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // Single-cycle ALU on the captured operands; unknown opcodes are flagged illegal.
  always_comb begin
    w_result = {DATA_W{1'b0}};
    w_carry  = 1'b0;
    w_legal  = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_result = w_diff[DATA_W-1:0];
        w_carry  = ~w_diff[DATA_W];
      end
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_SLL:  w_result = r_a << r_b[4:0];
      OP_SRL:  w_result = r_a >> r_b[4:0];
      OP_MUL:  w_result = w_mul_product;
      default: w_legal  = 1'b0;
    endcase
  end

  // Next-state logic; MUL leaves once the multiplier has finished its last iteration.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: w_next_state = ST_WB;
      ST_MUL: begin
        if (!w_mul_busy) begin
          w_next_state = ST_WB;
        end else begin
          w_next_state = ST_MUL;
        end
      end
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, request capture and registered writeback/flag outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= 4'd0;
      r_a     <= {DATA_W{1'b0}};
      r_b     <= {DATA_W{1'b0}};
      r_dest  <= {ADDR_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= w_to_wb;
      r_error <= w_to_wb && !w_legal;
      r_we    <= w_to_wb && w_legal;
      if (w_accept) begin
        r_op   <= opcode;
        r_a    <= operand_a;
        r_b    <= operand_b;
        r_dest <= dest_address;
      end
      if (w_to_wb) begin
        r_waddr <= r_dest;
        r_wdata <= w_result;
        if (w_legal) begin
          r_carry <= w_carry;
          r_zero  <= (w_result == {DATA_W{1'b0}});
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign write_enable  = r_we;
  assign write_address = r_waddr;
  assign write_data    = r_wdata;
  assign carry         = r_carry;
  assign zero          = r_zero;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand and result width; ADDR_W, default 5, register-bank address width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 opcode  input  4  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL; 8-15 illegal.
REQ-006 operand_a, operand_b  input  DATA_W  operands, fed from the register bank read_dataA/read_dataB.
REQ-007 dest_address  input  ADDR_W  destination register for the result.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 error  output  1  one-cycle pulse, coincident with done, for an illegal opcode.
REQ-011 write_enable  output  1  write strobe to the register bank.
REQ-012 write_address  output  ADDR_W  latched dest_address.
REQ-013 write_data  output  DATA_W  result.
REQ-014 carry, zero  output  1 each  flags from the last completed operation.

Function
REQ-015 States SHALL be IDLE, EXEC, MUL, WB; there SHALL be no other states.
REQ-016 IDLE with start=1 SHALL capture opcode, operands and dest_address at that edge (cycle T), then go to MUL if opcode=7, otherwise to EXEC.
REQ-017 start while busy=1 SHALL be ignored: no capture, no effect on the operation in flight.
REQ-018 EXEC SHALL compute the result in one cycle and then go to WB.
REQ-018a Single-cycle latency: done and write_enable SHALL be high during cycle T+2.
REQ-019 ADD/SUB SHALL be DATA_W-bit modular.
REQ-019a carry SHALL equal the carry-out for ADD.
REQ-019b carry SHALL equal NOT borrow for SUB (operand_a >= operand_b gives carry=1).
REQ-019c carry SHALL equal 0 for all other opcodes.
REQ-020 SLL/SRL SHALL be logical shifts by operand_b[4:0]; the upper bits of operand_b SHALL be ignored.
REQ-021 MUL SHALL be an iterative shift-add multiply using a 5-bit counter for 32 iterations.
REQ-021a MUL result SHALL be the low DATA_W bits of the product.
REQ-021b MUL SHALL go to WB when the counter reaches 31; done SHALL be high in cycle T+34.
REQ-022 WB SHALL last exactly one cycle: done=1, write_enable=1, write_address and write_data valid; next state IDLE.
REQ-022a A start in the WB cycle SHALL be ignored.
REQ-023 Illegal opcode SHALL take the EXEC path, with write_data=0, write_enable=0, done=1 and error=1 in WB.
REQ-023a carry and zero SHALL be left unchanged by an illegal opcode.
REQ-024 zero SHALL be 1 when write_data=0 for a legal opcode.
REQ-024a carry and zero SHALL update in the WB cycle and hold until the next WB.
REQ-025 write_address and write_data SHALL hold their last values outside WB.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE and set busy, done, error, write_enable, carry, zero, write_address, write_data and the counter to 0, including in the middle of an operation.
REQ-027 An aborted operation SHALL produce no write_enable and no done after reset deasserts.
REQ-027a The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the opcode constants, the state encoding, DATA_W and ADDR_W.
REQ-029 The shift-add multiplier SHALL be the one sub-module, alu_mul_iter, with ports start, operands, busy and product_lo.
REQ-029a The FSM, single-cycle ALU and writeback registers SHALL remain in alu_exec_unit.

Verification
REQ-030 ADD: a=0xFFFFFFFF, b=1, dest=3 -> at T+2: write_enable=1, write_address=3, write_data=0, carry=1, zero=1.
REQ-031 SUB: a=5, b=7 -> write_data=0xFFFFFFFE, carry=0, zero=0; SLL: a=1, b=0x24 -> write_data=0x10.
REQ-032 MUL: a=0x12345, b=0x100, dest=9 -> busy high for 34 cycles, done at T+34, write_data=0x01234500. A start pulsed at T+5 SHALL be ignored.
REQ-033 Illegal opcode 12 -> done=1, error=1, write_enable=0 at T+2; carry and zero unchanged.
REQ-034 Reset asserted at T+10 of a MUL -> outputs 0 at once, no done afterward; a following ADD 2+3 -> write_data=5 at its T+2.
REQ-035 Back-to-back: start held high continuously with ADD -> ops accepted every 3 cycles; exactly one write_enable per accepted op.
